// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit carry-look-ahead slice, one nibble per clock,
// with a registered inter-nibble carry and valid/ready handshakes on both sides.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Full look-ahead 4-bit slice: returns {c4, sum[3:0]}; no carry ripples bit to bit.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
        logic [3:0] p;
        logic [3:0] g;
        logic       c1;
        logic       c2;
        logic       c3;
        logic       c4;
        p  = x ^ y;
        g  = x & y;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, p ^ {c3, c2, c1, c0}};
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [IW-1:0]    idx_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;

    logic [3:0]       a_nib_s;
    logic [3:0]       b_nib_s;
    logic [4:0]       slice_s;

    // Select the operand nibbles addressed by idx and run them through the slice.
    always_comb begin
        a_nib_s = 4'b0000;
        b_nib_s = 4'b0000;
        for (int k = 0; k < NIB; k++) begin
            a_nib_s = (idx_r == IW'(k)) ? a_r[4*k +: 4] : a_nib_s;
            b_nib_s = (idx_r == IW'(k)) ? b_r[4*k +: 4] : b_nib_s;
        end
        slice_s = cla4(a_nib_s, b_nib_s, carry_r);
    end

    // Control FSM, operand/carry capture, nibble write-back and registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            idx_r       <= {IW{1'b0}};
            sum_r       <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r        <= a;
                        b_r        <= b;
                        carry_r    <= cin;
                        idx_r      <= {IW{1'b0}};
                        sum_r      <= {WIDTH{1'b0}};
                        cout_r     <= 1'b0;
                        state_r    <= ST_RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    for (int k = 0; k < NIB; k++) begin
                        if (idx_r == IW'(k)) begin
                            sum_r[4*k +: 4] <= slice_s[3:0];
                        end
                    end
                    carry_r <= slice_s[4];
                    idx_r   <= idx_r + IW'(1);
                    // The final nibble's carry becomes the architectural carry-out.
                    if (idx_r == LAST_IDX) begin
                        cout_r      <= slice_s[4];
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign sum       = sum_r;
    assign cout      = cout_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

endmodule
